// File: rtl/pipa_pulse_responder.sv
// One-axis PIPA responder: integrates ACCEL on PIPASW edges and answers PIPDAT edges
// with PIPAP/PIPAM pulses. Define PIPA_TERNARY_EN for the ternary (no-pulse dead band) loop.
module pipa_pulse_responder #(
    parameter int ACC_W   = 12,
    parameter int RES_W   = 20,
    parameter int QUANT   = 256,
    parameter int PULSE_W = 4
) (
    input  logic                    SIM_CLK,
    input  logic                    SIM_RST_n,
    input  logic                    PIPASW,
    input  logic                    PIPDAT,
    input  logic signed [ACC_W-1:0] ACCEL,
    input  logic                    CLRERR,
    output logic                    PIPAP,
    output logic                    PIPAM,
    output logic [15:0]             PCNT,
    output logic [15:0]             MCNT,
    output logic                    SEQERR,
    output logic                    SAT
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PULSE
    } state_t;

    // Residual clamp is symmetric, so the most negative code is never produced.
    localparam logic signed [RES_W:0]   SUM_MAX    = {2'b00, {(RES_W-1){1'b1}}};
    localparam logic signed [RES_W:0]   SUM_MIN    = -SUM_MAX;
    localparam logic signed [RES_W-1:0] QUANT_R    = RES_W'(QUANT);
    localparam logic [3:0]              PULSE_LAST = 4'(PULSE_W - 1);
`ifdef PIPA_TERNARY_EN
    localparam logic signed [RES_W-1:0] HALF_Q     = RES_W'(QUANT / 2);
    localparam logic signed [RES_W-1:0] NEG_HALF_Q = -HALF_Q;
`endif

    state_t                  state;
    state_t                  state_next;
    logic                    sw_prev;
    logic                    dat_prev;
    logic                    sw_edge;
    logic                    dat_edge;
    logic signed [RES_W-1:0] residual;
    logic signed [RES_W-1:0] residual_next;
    logic signed [RES_W:0]   sum;
    logic                    sum_hi;
    logic                    sum_lo;
    logic signed [RES_W-1:0] acc_result;
    logic                    dec_plus;
    logic                    dec_minus;
    logic [3:0]              pulse_left;
    logic [3:0]              pulse_left_next;
    logic                    sw_pending;
    logic                    sw_pending_next;
    logic                    plus_next;
    logic                    minus_next;
    logic [15:0]             pcnt_next;
    logic [15:0]             mcnt_next;
    logic                    set_seq;
    logic                    set_sat;
    logic                    seqerr_next;
    logic                    sat_next;

    assign sw_edge  = PIPASW & ~sw_prev;
    assign dat_edge = PIPDAT & ~dat_prev;

    always_comb begin
        sum        = {residual[RES_W-1], residual} + (RES_W+1)'(ACCEL);
        sum_hi     = sum > SUM_MAX;
        sum_lo     = sum < SUM_MIN;
        acc_result = sum[RES_W-1:0];
        if (sum_hi) begin
            acc_result = SUM_MAX[RES_W-1:0];
        end else if (sum_lo) begin
            acc_result = SUM_MIN[RES_W-1:0];
        end
    end

    always_comb begin
`ifdef PIPA_TERNARY_EN
        dec_plus  = residual >= HALF_Q;
        dec_minus = residual <= NEG_HALF_Q;
`else
        dec_plus  = ~residual[RES_W-1];
        dec_minus = residual[RES_W-1];
`endif
    end

    always_comb begin
        state_next      = state;
        residual_next   = residual;
        pulse_left_next = pulse_left;
        sw_pending_next = sw_pending;
        plus_next       = PIPAP;
        minus_next      = PIPAM;
        pcnt_next       = PCNT;
        mcnt_next       = MCNT;
        set_seq         = sw_edge & dat_edge;
        set_sat         = sw_edge & (sum_hi | sum_lo);

        if (sw_edge) begin
            residual_next = acc_result;
        end

        unique case (state)
            IDLE: begin
                if (sw_edge) begin
                    state_next = ARMED;
                end else if (dat_edge) begin
                    set_seq = 1'b1;
                end
            end
            ARMED: begin
                if (dat_edge && !sw_edge) begin
                    state_next = IDLE;
                    if (dec_plus) begin
                        residual_next   = residual - QUANT_R;
                        plus_next       = 1'b1;
                        pcnt_next       = PCNT + 16'd1;
                        pulse_left_next = PULSE_LAST;
                        state_next      = PULSE;
                    end else if (dec_minus) begin
                        residual_next   = residual + QUANT_R;
                        minus_next      = 1'b1;
                        mcnt_next       = MCNT + 16'd1;
                        pulse_left_next = PULSE_LAST;
                        state_next      = PULSE;
                    end
                end
            end
            PULSE: begin
                if (sw_edge) begin
                    sw_pending_next = 1'b1;
                end
                if (dat_edge) begin
                    set_seq = 1'b1;
                end
                if (pulse_left == 4'd0) begin
                    plus_next       = 1'b0;
                    minus_next      = 1'b0;
                    sw_pending_next = 1'b0;
                    state_next      = (sw_pending || sw_edge) ? ARMED : IDLE;
                end else begin
                    pulse_left_next = pulse_left - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A flag being set this cycle takes priority over the clear request.
        seqerr_next = set_seq | (SEQERR & ~CLRERR);
        sat_next    = set_sat | (SAT & ~CLRERR);
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state      <= IDLE;
            sw_prev    <= 1'b0;
            dat_prev   <= 1'b0;
            residual   <= '0;
            pulse_left <= 4'd0;
            sw_pending <= 1'b0;
            PIPAP      <= 1'b0;
            PIPAM      <= 1'b0;
            PCNT       <= 16'd0;
            MCNT       <= 16'd0;
            SEQERR     <= 1'b0;
            SAT        <= 1'b0;
        end else begin
            state      <= state_next;
            sw_prev    <= PIPASW;
            dat_prev   <= PIPDAT;
            residual   <= residual_next;
            pulse_left <= pulse_left_next;
            sw_pending <= sw_pending_next;
            PIPAP      <= plus_next;
            PIPAM      <= minus_next;
            PCNT       <= pcnt_next;
            MCNT       <= mcnt_next;
            SEQERR     <= seqerr_next;
            SAT        <= sat_next;
        end
    end

endmodule

// File: tb/tb_pipa_pulse_responder.sv
// Bench for pipa_pulse_responder: directed scenarios plus random strobes, all checked
// every cycle against a time-based behavioural model of the PIPA loop.
module tb_pipa_pulse_responder;

    localparam int ACC_W   = 12;
    localparam int RES_W   = 20;
    localparam int QUANT   = 256;
    localparam int PULSE_W = 4;
    localparam int RMAX    = (1 << (RES_W - 1)) - 1;

    logic                    SIM_CLK = 1'b0;
    logic                    SIM_RST_n = 1'b0;
    logic                    sw_in = 1'b0;
    logic                    dat_in = 1'b0;
    logic signed [ACC_W-1:0] accel_in = '0;
    logic                    clr_in = 1'b0;
    logic                    PIPAP;
    logic                    PIPAM;
    logic [15:0]             PCNT;
    logic [15:0]             MCNT;
    logic                    SEQERR;
    logic                    SAT;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    pipa_pulse_responder #(
        .ACC_W(ACC_W), .RES_W(RES_W), .QUANT(QUANT), .PULSE_W(PULSE_W)
    ) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n), .PIPASW(sw_in), .PIPDAT(dat_in),
        .ACCEL(accel_in), .CLRERR(clr_in), .PIPAP(PIPAP), .PIPAM(PIPAM),
        .PCNT(PCNT), .MCNT(MCNT), .SEQERR(SEQERR), .SAT(SAT)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    // Model: a pulse is a time window [decision+1, decision+PULSE_W]; the loop is
    // either busy with that window, armed by a switch strobe, or waiting.
    int          m_r = 0;
    int          m_end = -1;
    int          cyc = 0;
    bit          m_sw_prev = 0;
    bit          m_dat_prev = 0;
    bit          m_armed = 0;
    bit          m_pending = 0;
    bit          m_plus = 0;
    bit          m_seq = 0;
    bit          m_sat = 0;
    bit          exp_p = 0;
    bit          exp_m = 0;
    logic [15:0] m_pcnt = 16'd0;
    logic [15:0] m_mcnt = 16'd0;

    always @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            m_r = 0; m_end = -1; m_sw_prev = 0; m_dat_prev = 0;
            m_armed = 0; m_pending = 0; m_plus = 0; m_seq = 0; m_sat = 0;
            m_pcnt = 16'd0; m_mcnt = 16'd0; exp_p = 0; exp_m = 0;
        end else begin : step
            bit sw_e, dat_e, busy, seq_set, sat_set;
            int sum, dir;
            cyc++;
            sw_e  = sw_in && !m_sw_prev;
            dat_e = dat_in && !m_dat_prev;
            m_sw_prev  = sw_in;
            m_dat_prev = dat_in;
            busy    = (cyc <= m_end);
            seq_set = 0;
            sat_set = 0;
            if (sw_e) begin
                sum = m_r + int'(accel_in);
                if (sum > RMAX) begin m_r = RMAX; sat_set = 1; end
                else if (sum < -RMAX) begin m_r = -RMAX; sat_set = 1; end
                else m_r = sum;
                if (busy) m_pending = 1; else m_armed = 1;
                if (dat_e) seq_set = 1;
            end else if (dat_e) begin
                if (busy || !m_armed) begin
                    seq_set = 1;
                end else begin
`ifdef PIPA_TERNARY_EN
                    if (m_r >= QUANT / 2) dir = 1;
                    else if (m_r <= -(QUANT / 2)) dir = -1;
                    else dir = 0;
`else
                    dir = (m_r >= 0) ? 1 : -1;
`endif
                    m_armed = 0;
                    if (dir != 0) begin
                        m_r    = m_r - dir * QUANT;
                        m_plus = (dir > 0);
                        m_end  = cyc + PULSE_W;
                        if (dir > 0) m_pcnt = m_pcnt + 16'd1;
                        else m_mcnt = m_mcnt + 16'd1;
                    end
                end
            end
            if (busy && cyc == m_end) begin
                m_armed   = m_pending;
                m_pending = 0;
            end
            if (seq_set) m_seq = 1; else if (clr_in) m_seq = 0;
            if (sat_set) m_sat = 1; else if (clr_in) m_sat = 0;
            exp_p = m_plus && (cyc < m_end);
            exp_m = !m_plus && (cyc < m_end);
        end
    end

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge SIM_CLK) begin
        if (cmp_en) begin
            checkOutput("PIPAP", PIPAP, exp_p);
            checkOutput("PIPAM", PIPAM, exp_m);
            checkOutput("PCNT", PCNT, m_pcnt);
            checkOutput("MCNT", MCNT, m_mcnt);
            checkOutput("SEQERR", SEQERR, m_seq);
            checkOutput("SAT", SAT, m_sat);
            checkOutput("exclusive", PIPAP & PIPAM, 0);
        end
    end

    task automatic applyStimulus(input bit sw, input bit dat, input int acc, input bit clr);
        @(negedge SIM_CLK);
        sw_in    = sw;
        dat_in   = dat;
        accel_in = ACC_W'(acc);
        clr_in   = clr;
    endtask

    task automatic resetDut();
        @(posedge SIM_CLK);
        #2;
        SIM_RST_n = 1'b0;
        sw_in = 0; dat_in = 0; accel_in = '0; clr_in = 0;
        repeat (2) @(posedge SIM_CLK);
        #2 SIM_RST_n = 1'b1;
    endtask

    initial begin
        int hi, first_hi;
        repeat (3) @(posedge SIM_CLK);
        #2 SIM_RST_n = 1'b1;
        cmp_en = 1'b1;

        $display("[TB] reset values");
        applyStimulus(0, 0, 0, 0);
        checkOutput("reset_pcnt", PCNT, 0);
        checkOutput("reset_mcnt", MCNT, 0);
        checkOutput("reset_pipap", PIPAP, 0);

        $display("[TB] ACCEL=-300 single pair");
        applyStimulus(1, 0, -300, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        hi = 0;
        first_hi = -1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (PIPAM) begin
                hi++;
                if (first_hi < 0) first_hi = i;
            end
        end
        checkOutput("minus_start", first_hi, 0);
        checkOutput("minus_len", hi, PULSE_W);
        checkOutput("model_r_m44", m_r, -44);
        checkOutput("mcnt_one", MCNT, 1);

        $display("[TB] simultaneous strobes then data");
        resetDut();
        applyStimulus(1, 1, 256, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("model_r_256", m_r, 256);
        checkOutput("seqerr_simul", SEQERR, 1);
        checkOutput("no_pulse_simul", PIPAP | PIPAM, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("plus_after", PIPAP, 1);
        checkOutput("model_r_0", m_r, 0);

        $display("[TB] sequence errors and clear");
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("seqerr_cleared", SEQERR, 0);
        repeat (6) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("seqerr_idle", SEQERR, 1);
        checkOutput("pcnt_unchanged", PCNT, 1);

        $display("[TB] saturation");
        resetDut();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1, 0, 2047, 0);
            applyStimulus(0, 0, 2047, 0);
        end
        checkOutput("model_r_clamp", m_r, 524287);
        checkOutput("sat_set", SAT, 1);

        $display("[TB] reset during pulse");
        resetDut();
        applyStimulus(1, 0, 200, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        @(posedge SIM_CLK);
        #2 SIM_RST_n = 1'b0;
        #1;
        checkOutput("rst_pipap", PIPAP, 0);
        checkOutput("rst_pcnt", PCNT, 0);
        repeat (2) @(posedge SIM_CLK);
        #2 SIM_RST_n = 1'b1;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("idle_after_rst", SEQERR, 1);
        checkOutput("no_pulse_after_rst", PIPAP | PIPAM, 0);

        $display("[TB] random strobes");
        resetDut();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                          int'($urandom_range(0, 4095)) - 2048, $urandom_range(0, 15) == 0);
        end
        repeat (PULSE_W + 2) applyStimulus(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
